lcd_output_sequencer: RTL and testbench

// - Avalon-MM slave driving the 12-bit character-LCD pin bus; parametrised successor to the direct-write LCD PIO.
// - Legacy DIRECT mode: software writes pins as a register. SEQ mode: software pushes cmd/data bytes into a FIFO.
// - In SEQ mode the FSM generates RS/RW/E setup, pulse, hold and per-command wait timing without CPU polling.

---
 rtl/lcd_output_pkg.sv | 36 +++
 rtl/lcd_output_sequencer_fifo.sv | 66 ++++++
 rtl/lcd_output_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_output_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_output_pkg.sv
// lcd_output_pkg
// Shared definitions for the LCD output sequencer: Avalon register offsets,
// STATUS/CONTROL bit positions, sequencer FSM state encoding and the two
// slow HD44780-style opcodes (clear display, return home).
package lcd_output_pkg;

  // Register offsets on the 2-bit word address
  localparam logic [1:0] ADDR_DIRECT  = 2'd0;
  localparam logic [1:0] ADDR_FIFO_WR = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  // STATUS bits (level occupies [7:0])
  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_BUSY  = 10;
  localparam int STAT_OVF   = 11;

  // CONTROL bits
  localparam int CTRL_MODE   = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_LCD_ON = 2;

  // Commands that need the long post-command wait
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/lcd_output_sequencer_fifo.sv
// lcd_cmd_fifo
// Synchronous show-ahead FIFO holding {rs, data} entries for the sequencer.
// dout always presents the head entry so the FSM can pop and latch it in
// the same cycle.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   push, din    : write request and entry (dropped when full unless a pop
//                  happens in the same cycle)
//   pop          : remove head entry (ignored when empty)
//   flush        : empty the FIFO at the next edge
//   dout         : head entry
//   level        : number of stored entries
//   full, empty  : occupancy flags
module lcd_cmd_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty = (r_level == '0);
  assign full  = (r_level == (AW+1)'(DEPTH));
  assign level = r_level;
  assign dout  = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so push-when-full still succeeds
  // if it coincides with a pop.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // Storage carries no reset; stale contents are never visible because the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/lcd_output_sequencer.sv
// lcd_output_sequencer
// Avalon-MM slave driving a character-LCD pin bus. In DIRECT mode the pins
// follow a software register; in SEQ mode cmd/data bytes queued in a FIFO
// are played out with RS/data setup, E pulse, hold and a per-command wait.
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   address, chipselect,
//   write_n, writedata      : Avalon write side (write = chipselect & ~write_n)
//   readdata                : combinational read mux, no side effects
//   out_port                : {lcd_on, lcd_en, lcd_rw, lcd_rs, lcd_data}
module lcd_output_sequencer
  import lcd_output_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int T_SETUP    = 2,
  parameter int T_EN       = 25,
  parameter int T_HOLD     = 2,
  parameter int T_WAIT     = 2000,
  parameter int T_WAIT_CLR = 82000,
  parameter int CNT_W      = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W+3:0] out_port
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              w_wr;
  logic              w_wr_direct;
  logic              w_wr_fifo;
  logic              w_wr_status;
  logic              w_wr_ctrl;
  logic              w_flush;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W:0]   w_fifo_dout;
  logic [LVL_W-1:0]  w_level;
  logic              w_slow_cmd;
  logic              w_unused;

  logic [DATA_W+3:0] r_direct;
  logic              r_mode_req;
  logic              r_mode;
  logic              r_lcd_on;
  logic              r_overflow;
  logic              r_rs;
  logic [DATA_W-1:0] r_data;
  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic [CNT_W-1:0]  r_timer;
  logic [CNT_W-1:0]  w_timer_next;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_direct = w_wr && (address == ADDR_DIRECT);
  assign w_wr_fifo   = w_wr && (address == ADDR_FIFO_WR);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);
  assign w_wr_ctrl   = w_wr && (address == ADDR_CONTROL);
  assign w_flush     = w_wr_ctrl && writedata[CTRL_FLUSH];

  // Not every writedata bit maps to a register
  assign w_unused = ^writedata;

  lcd_cmd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_wr_fifo),
    .pop     (w_pop),
    .flush   (w_flush),
    .din     (writedata[DATA_W:0]),
    .dout    (w_fifo_dout),
    .level   (w_level),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Clear and home commands need the long wait after the pulse
  assign w_slow_cmd = !r_rs && ((r_data == DATA_W'(OP_CLEAR)) ||
                                (r_data == DATA_W'(OP_HOME)));

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_mode && !w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_SETUP;
          w_timer_next = CNT_W'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (r_timer == '0) begin
          w_state_next = ST_PULSE;
          w_timer_next = CNT_W'(T_EN - 1);
        end else begin
          w_timer_next = r_timer - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (r_timer == '0) begin
          w_state_next = ST_HOLD;
          w_timer_next = CNT_W'(T_HOLD - 1);
        end else begin
          w_timer_next = r_timer - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (r_timer == '0) begin
          w_state_next = ST_WAIT;
          w_timer_next = w_slow_cmd ? CNT_W'(T_WAIT_CLR - 1) : CNT_W'(T_WAIT - 1);
        end else begin
          w_timer_next = r_timer - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (r_timer == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_timer_next = r_timer - CNT_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Flush aborts any transaction in flight and must not pop the entry
    // that is about to be discarded.
    if (w_flush) begin
      w_state_next = ST_IDLE;
      w_pop        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_rs    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      if (w_pop) {r_rs, r_data} <= w_fifo_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_direct   <= '0;
      r_mode_req <= 1'b0;
      r_mode     <= 1'b0;
      r_lcd_on   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_direct) r_direct <= writedata[DATA_W+3:0];
      if (w_wr_ctrl) begin
        r_mode_req <= writedata[CTRL_MODE];
        r_lcd_on   <= writedata[CTRL_LCD_ON];
      end
      // The active mode only follows the request between transactions, so
      // an E pulse is never cut short by a mode change.
      if (r_state == ST_IDLE) r_mode <= r_mode_req;
      if (w_wr_fifo && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (w_wr_status && writedata[STAT_OVF]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DIRECT: readdata[DATA_W+3:0] = r_direct;
      ADDR_STATUS: begin
        readdata[LVL_W-1:0]  = w_level;
        readdata[STAT_EMPTY] = w_empty;
        readdata[STAT_FULL]  = w_full;
        readdata[STAT_BUSY]  = (r_state != ST_IDLE);
        readdata[STAT_OVF]   = r_overflow;
      end
      ADDR_CONTROL: begin
        readdata[CTRL_MODE]   = r_mode_req;
        readdata[CTRL_LCD_ON] = r_lcd_on;
      end
      default: readdata = '0;
    endcase
  end

  assign out_port = r_mode ? {r_lcd_on, (r_state == ST_PULSE), 1'b0, r_rs, r_data}
                           : r_direct;

endmodule

// File: tb/tb_lcd_output_sequencer.sv
// Testbench for lcd_output_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized traffic, all checked every cycle
// against a transaction-level reference model.
module tb_lcd_output_sequencer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int TS     = 2;
  localparam int TE     = 4;
  localparam int TH     = 2;
  localparam int TW     = 10;
  localparam int TWC    = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [11:0] out_port;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lcd_output_sequencer #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .T_SETUP(TS), .T_EN(TE),
    .T_HOLD(TH), .T_WAIT(TW), .T_WAIT_CLR(TWC), .CNT_W(17)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  // ---------------- reference model ----------------
  // m_e: cycles elapsed since the pop edge of the current byte, -1 when idle.
  int          m_e = -1;
  int          m_len = 0;
  logic [8:0]  m_q[$];
  logic [8:0]  m_cur = 9'd0;
  bit          m_mode = 0, m_mode_req = 0, m_on = 0, m_ovf = 0;
  logic [11:0] m_direct = 12'd0;

  function automatic int txn_len(input logic [8:0] ent);
    bit slow = !ent[8] && (ent[7:0] == 8'h01 || ent[7:0] == 8'h02);
    return TS + TE + TH + (slow ? TWC : TW);
  endfunction

  task automatic model_step(input bit rst_n, input bit wr, input logic [1:0] a, input logic [31:0] d);
    bit was_idle, flush, pop;
    if (!rst_n) begin
      m_e = -1; m_q.delete(); m_cur = 9'd0; m_mode = 0; m_mode_req = 0;
      m_on = 0; m_ovf = 0; m_direct = 12'd0;
      return;
    end
    was_idle = (m_e < 0);
    flush = wr && (a == 2'd3) && d[1];
    pop = was_idle && m_mode && (m_q.size() > 0) && !flush;
    if (flush) begin
      m_q.delete(); m_e = -1;
    end else if (pop) begin
      m_cur = m_q.pop_front(); m_e = 0; m_len = txn_len(m_cur);
    end else if (m_e >= 0) begin
      m_e++;
      if (m_e == m_len) m_e = -1;
    end
    if (was_idle) m_mode = m_mode_req;
    if (wr) begin
      case (a)
        2'd0: m_direct = d[11:0];
        2'd1: if (m_q.size() < DEPTH) m_q.push_back(d[8:0]); else m_ovf = 1;
        2'd2: if (d[11]) m_ovf = 0;
        default: begin m_mode_req = d[0]; m_on = d[2]; end
      endcase
    end
  endtask

  function automatic logic [11:0] exp_out();
    bit en = (m_e >= TS) && (m_e < TS + TE);
    return m_mode ? {m_on, en, 1'b0, m_cur} : m_direct;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic [31:0] r = 32'd0;
    case (a)
      2'd0: r[11:0] = m_direct;
      2'd2: begin
        r[7:0] = 8'(m_q.size());
        r[8]   = (m_q.size() == 0);
        r[9]   = (m_q.size() == DEPTH);
        r[10]  = (m_e >= 0);
        r[11]  = m_ovf;
      end
      2'd3: begin r[0] = m_mode_req; r[2] = m_on; end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, advance model at posedge, compare after.
  task automatic tick(input bit cs, input bit we, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = cs; write_n = !we; address = a; writedata = d;
    @(posedge clk);
    model_step(reset_n, cs && we, a, d);
    #1;
    check("out_port", 32'(out_port), 32'(exp_out()));
    check("readdata", readdata, exp_read(a));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(1'b1, 1'b0, 2'd2, 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic wait_en(input string name, input int max);
    bit found = 0;
    for (int i = 0; i < max && !found; i++) begin
      tick(1'b1, 1'b0, 2'd2, 32'd0);
      found = out_port[10];
    end
    check(name, 32'(found), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic [11:0] exp_out;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n_busy, n_en, first_busy, first_en, last_en, r1, f1, r2, n_pulse, n_bad;
    bit prev_en, found;
    logic [1:0] ra;
    logic [31:0] rd;
    bit en_tr[80];

    tbl[0] = '{2'd0, 32'h0000_0ABC, 2'd0, 32'h0000_0ABC, 12'hABC};
    tbl[1] = '{2'd3, 32'h0000_0004, 2'd3, 32'h0000_0004, 12'hABC};
    tbl[2] = '{2'd1, 32'h0000_0155, 2'd1, 32'h0000_0000, 12'hABC};
    tbl[3] = '{2'd2, 32'h0000_0000, 2'd2, 32'h0000_0001, 12'hABC};
    tbl[4] = '{2'd0, 32'hFFFF_F123, 2'd0, 32'h0000_0123, 12'h123};
    tbl[5] = '{2'd3, 32'hFFFF_FFFA, 2'd3, 32'h0000_0000, 12'h123};
    tbl[6] = '{2'd2, 32'h0000_0800, 2'd2, 32'h0000_0100, 12'h123};

    // Reset state
    do_reset();
    check("reset_out", 32'(out_port), 32'h0);
    check("reset_status", readdata, 32'h100);

    // Directed register vectors (DIRECT mode)
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b1, tbl[i].a, tbl[i].d);
      tick(1'b1, 1'b0, tbl[i].ra, 32'd0);
      check($sformatf("vec%0d_read", i), readdata, tbl[i].exp_rd);
      check($sformatf("vec%0d_out", i), 32'(out_port), 32'(tbl[i].exp_out));
    end

    // SEQ single byte
    do_reset();
    tick(1'b1, 1'b1, 2'd3, 32'h5);
    tick(1'b1, 1'b1, 2'd1, 32'h141);
    n_busy = 0; n_en = 0; first_busy = -1; first_en = -1; last_en = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, 1'b0, 2'd2, 32'd0);
      if (readdata[10]) begin
        n_busy++;
        if (first_busy < 0) begin
          first_busy = i;
          check("single_setup_out", 32'(out_port), 32'h941);
        end
      end
      if (out_port[10]) begin
        n_en++; last_en = i;
        if (first_en < 0) begin
          first_en = i;
          check("single_pulse_out", 32'(out_port), 32'hD41);
        end
      end
    end
    check("single_busy_cycles", n_busy, 32'd18);
    check("single_en_cycles", n_en, 32'd4);
    check("single_setup_len", first_en - first_busy, 32'd2);
    check("single_en_contig", last_en - first_en, 32'd3);

    // Clear command followed by a queued byte
    do_reset();
    tick(1'b1, 1'b1, 2'd3, 32'h5);
    tick(1'b1, 1'b1, 2'd1, 32'h001);
    tick(1'b1, 1'b1, 2'd1, 32'h141);
    for (int i = 0; i < 80; i++) begin
      tick(1'b1, 1'b0, 2'd2, 32'd0);
      en_tr[i] = out_port[10];
    end
    r1 = -1; f1 = -1; r2 = -1;
    for (int i = 0; i < 80; i++) begin
      if (r1 < 0 && en_tr[i]) r1 = i;
      else if (r1 >= 0 && f1 < 0 && !en_tr[i]) f1 = i;
      else if (f1 >= 0 && r2 < 0 && en_tr[i]) r2 = i;
    end
    check("clr_first_pulse_len", f1 - r1, 32'd4);
    check("clr_gap_to_next_en", r2 - f1, 32'(TH + TWC + 1 + TS));

    // Overflow
    do_reset();
    tick(1'b1, 1'b1, 2'd3, 32'h5);
    tick(1'b1, 1'b1, 2'd1, 32'h130);
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, 2'd1, 32'h131 + 32'(k));
    tick(1'b1, 1'b0, 2'd2, 32'd0);
    check("ovf_status", readdata, 32'hE04);
    tick(1'b1, 1'b1, 2'd2, 32'h800);
    tick(1'b1, 1'b0, 2'd2, 32'd0);
    check("ovf_cleared", readdata, 32'h604);
    n_pulse = 0; prev_en = out_port[10];
    for (int i = 0; i < 150; i++) begin
      tick(1'b1, 1'b0, 2'd2, 32'd0);
      if (out_port[10] && !prev_en) n_pulse++;
      prev_en = out_port[10];
    end
    check("ovf_pulse_count", n_pulse, 32'd4);
    check("ovf_drained", readdata, 32'h100);

    // Flush during PULSE
    do_reset();
    tick(1'b1, 1'b1, 2'd3, 32'h5);
    tick(1'b1, 1'b1, 2'd1, 32'h141);
    tick(1'b1, 1'b1, 2'd1, 32'h142);
    wait_en("flush_wait_en", 20);
    tick(1'b1, 1'b1, 2'd3, 32'h7);
    check("flush_en_low", 32'(out_port[10]), 32'd0);
    tick(1'b1, 1'b0, 2'd2, 32'd0);
    check("flush_status", readdata, 32'h100);
    tick(1'b1, 1'b1, 2'd1, 32'h143);
    n_en = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1'b1, 1'b0, 2'd2, 32'd0);
      if (out_port[10]) begin
        n_en++;
        check("flush_after_out", 32'(out_port), 32'hD43);
      end
    end
    check("flush_after_en", n_en, 32'd4);

    // Mode switch during PULSE
    do_reset();
    tick(1'b1, 1'b1, 2'd0, 32'h3C3);
    tick(1'b1, 1'b1, 2'd3, 32'h5);
    tick(1'b1, 1'b1, 2'd1, 32'h155);
    wait_en("mode_wait_en", 20);
    n_en = 1; n_bad = 0; found = 0;
    tick(1'b1, 1'b1, 2'd3, 32'h4);
    if (out_port[10]) n_en++;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b1, 1'b0, 2'd2, 32'd0);
      if (out_port[10]) n_en++;
      if (readdata[10] && out_port[8:0] != 9'h155) n_bad++;
      found = !readdata[10];
    end
    check("mode_reach_idle", 32'(found), 32'd1);
    check("mode_pulse_len", n_en, 32'd4);
    check("mode_seq_held", n_bad, 32'd0);
    tick(1'b1, 1'b0, 2'd2, 32'd0);
    check("mode_direct_out", 32'(out_port), 32'h3C3);

    // Reset during WAIT
    do_reset();
    tick(1'b1, 1'b1, 2'd3, 32'h5);
    tick(1'b1, 1'b1, 2'd1, 32'h141);
    wait_en("rst_wait_en", 20);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 2'd2, 32'd0);
    check("rst_busy_before", 32'(readdata[10]), 32'd1);
    do_reset();
    check("rst_out", 32'(out_port), 32'h0);
    check("rst_status", readdata, 32'h100);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      ra = 2'($urandom_range(0, 3));
      rd = $urandom;
      if (r == 0 && $urandom_range(0, 3) == 0) reset_n = 1'b0;
      if (r < 45) begin
        tick(1'b1, 1'b0, ra, rd);
      end else if (r < 70) begin
        if ($urandom_range(0, 3) == 0) rd[8:0] = 9'($urandom_range(0, 3));
        tick(1'b1, 1'b1, 2'd1, rd);
      end else if (r < 75) begin
        tick(1'b1, 1'b1, 2'd0, rd);
      end else if (r < 80) begin
        tick(1'b1, 1'b1, 2'd2, rd);
      end else if (r < 88) begin
        rd[0] = ($urandom_range(0, 9) < 8);
        rd[1] = ($urandom_range(0, 9) == 0);
        tick(1'b1, 1'b1, 2'd3, rd);
      end else if (r < 93) begin
        tick(1'b0, 1'b1, ra, rd);
      end else begin
        tick(1'b0, 1'b0, ra, rd);
      end
      reset_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
